// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with word-addressed memory bank, fixed wait states and error response
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  ACCESS cycles with PREADY low before completion (0..15)
//   BASE_ADDR    byte address of word 0 (aligned to DEPTH*4)
// Ports:
//   PCLK, PRESETn            bus clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE    APB control from the master
//   PADDR, PWDATA            byte address and write data (captured in setup phase)
//   PSTRB                    write byte-lane strobes (only when APB_SLAVE_PSTRB_EN is defined)
//   PREADY, PRDATA, PSLVERR  completion, read data and error response
// Optional feature macro: APB_SLAVE_PSTRB_EN
module apb_slave_mem #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
    input  logic [3:0]  PSTRB,
`endif
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        capture;
    logic        complete;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
`ifdef APB_SLAVE_PSTRB_EN
    logic [3:0]  strb_q;
`endif

    logic [31:0] mem [DEPTH];

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             addr_err;

    // Decode works only on the captured address so PADDR may change during ACCESS.
    assign offset   = addr_q - BASE_ADDR;
    assign idx      = offset[IDX_W+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) || ((offset >> 2) >= 32'(DEPTH));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        complete  = 1'b0;
        PREADY    = 1'b0;
        case (state)
            IDLE: begin
                // PSEL && PENABLE while idle is a protocol violation and is ignored.
                if (PSEL && !PENABLE) begin
                    capture   = 1'b1;
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    // Master abandoned the transfer: no write, no completion.
                    state_nxt = IDLE;
                end else if (PENABLE) begin
                    if (cnt != 4'd0) begin
                        cnt_nxt = cnt - 4'd1;
                    end else begin
                        PREADY    = 1'b1;
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign PSLVERR = PREADY && addr_err;
    assign PRDATA  = (PREADY && !write_q && !addr_err) ? mem[idx] : 32'h0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            write_q <= 1'b0;
`ifdef APB_SLAVE_PSTRB_EN
            strb_q  <= 4'h0;
`endif
        end else if (capture) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
`ifdef APB_SLAVE_PSTRB_EN
            strb_q  <= PSTRB;
`endif
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 32'h0;
            end
        end else if (complete && write_q && !addr_err) begin
`ifdef APB_SLAVE_PSTRB_EN
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
`else
            mem[idx] <= wdata_q;
`endif
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - self-checking bench for apb_slave_mem (four instances with different wait/base settings)
module tb_apb_slave_mem;

    localparam int NDUT = 4;

    logic        PCLK = 1'b0;
    logic        rst_n;
    logic        psel    [NDUT];
    logic        penable [NDUT];
    logic        pwrite  [NDUT];
    logic [31:0] paddr   [NDUT];
    logic [31:0] pwdata  [NDUT];
    logic [3:0]  pstrb   [NDUT];
    logic        pready  [NDUT];
    logic [31:0] prdata  [NDUT];
    logic        pslverr [NDUT];

    int total  = 0;
    int passed = 0;

    always #5 PCLK = ~PCLK;

    // dut 0: WAIT 0, base 0; dut 1: WAIT 2; dut 2: WAIT 3; dut 3: WAIT 1, base 0x100
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb_slave_mem #(
            .DEPTH      (16),
            .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 2 : g == 2 ? 3 : 1),
            .BASE_ADDR  (g == 3 ? 32'h0000_0100 : 32'h0000_0000)
        ) u_dut (
            .PCLK   (PCLK),
            .PRESETn(rst_n),
            .PSEL   (psel[g]),
            .PENABLE(penable[g]),
            .PWRITE (pwrite[g]),
            .PADDR  (paddr[g]),
            .PWDATA (pwdata[g]),
`ifdef APB_SLAVE_PSTRB_EN
            .PSTRB  (pstrb[g]),
`endif
            .PREADY (pready[g]),
            .PRDATA (prdata[g]),
            .PSLVERR(pslverr[g])
        );
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : (d == 2) ? 3 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Entered at posedge+1; returns at posedge+1 with the bus idle so a
    // following call starts its setup phase with no bubble.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er, output int nacc);
        bit ok;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
        @(posedge PCLK); #1;
        penable[d] = 1'b1;
        // Captured values must be used, so corrupt the live bus during ACCESS.
        paddr[d] = ~a; pwdata[d] = ~wd; pstrb[d] = ~st;
        nacc = 0; ok = 1'b0; rd = 32'h0; er = 1'b0;
        while (!ok && nacc < 40) begin
            @(negedge PCLK);
            nacc++;
            if (pready[d]) begin
                rd = prdata[d]; er = pslverr[d]; ok = 1'b1;
            end else begin
                chk("wait_pslverr_low", {31'b0, pslverr[d]}, 32'h0);
            end
            @(posedge PCLK); #1;
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
        if (!ok) chk("timeout_pready", 32'h0, 32'h1);
    endtask

    typedef struct {
        int          d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          nacc;

        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            psel[i] = 0; penable[i] = 0; pwrite[i] = 0;
            paddr[i] = 0; pwdata[i] = 0; pstrb[i] = 4'hF;
        end

        vecs[0]  = '{0, 0, 32'h08, 32'h0,        32'h0,        0};
        vecs[1]  = '{0, 1, 32'h04, 32'hDEADBEEF, 32'h0,        0};
        vecs[2]  = '{0, 0, 32'h04, 32'h0,        32'hDEADBEEF, 0};
        vecs[3]  = '{1, 1, 32'h04, 32'hDEADBEEF, 32'h0,        0};
        vecs[4]  = '{1, 0, 32'h04, 32'h0,        32'hDEADBEEF, 0};
        vecs[5]  = '{0, 1, 32'h40, 32'h12345678, 32'h0,        1};
        vecs[6]  = '{0, 1, 32'h06, 32'h12345678, 32'h0,        1};
        vecs[7]  = '{0, 0, 32'h04, 32'h0,        32'hDEADBEEF, 0};
        vecs[8]  = '{0, 1, 32'h3C, 32'hCAFEF00D, 32'h0,        0};
        vecs[9]  = '{0, 0, 32'h3C, 32'h0,        32'hCAFEF00D, 0};
        vecs[10] = '{0, 0, 32'h40, 32'h0,        32'h0,        1};
        vecs[11] = '{3, 0, 32'hFC, 32'h0,        32'h0,        1};
        vecs[12] = '{3, 1, 32'h13C, 32'h0BADC0DE, 32'h0,       0};
        vecs[13] = '{3, 0, 32'h13C, 32'h0,       32'h0BADC0DE, 0};
        vecs[14] = '{3, 0, 32'h140, 32'h0,       32'h0,        1};

        repeat (3) @(posedge PCLK);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("reset_pready",  {31'b0, pready[i]},  32'h0);
            chk("reset_prdata",  prdata[i],           32'h0);
            chk("reset_pslverr", {31'b0, pslverr[i]}, 32'h0);
        end
        rst_n = 1'b1;
        @(posedge PCLK); #1;

        foreach (vecs[i]) begin
            xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, rd, er, nacc);
            chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_access_cycles", i), nacc, wait_of(vecs[i].d) + 1);
        end

        // Abort: drop PSEL after one ACCESS cycle of a WAIT=3 write.
        psel[2] = 1; penable[2] = 0; pwrite[2] = 1; paddr[2] = 32'h0C; pwdata[2] = 32'hAAAA5555; pstrb[2] = 4'hF;
        @(posedge PCLK); #1;
        penable[2] = 1;
        @(negedge PCLK);
        chk("abort_pready_access1", {31'b0, pready[2]}, 32'h0);
        @(posedge PCLK); #1;
        psel[2] = 0; penable[2] = 0;
        @(negedge PCLK);
        chk("abort_pready_after", {31'b0, pready[2]}, 32'h0);
        @(posedge PCLK); #1;
        xfer(2, 0, 32'h0C, 32'h0, 4'hF, rd, er, nacc);
        chk("abort_readback", rd, 32'h0);
        chk("abort_read_cycles", nacc, 4);

        // Protocol violation: PSEL && PENABLE in IDLE without setup is ignored.
        psel[0] = 1; penable[0] = 1; pwrite[0] = 0; paddr[0] = 32'h04;
        @(negedge PCLK);
        chk("violation_pready", {31'b0, pready[0]}, 32'h0);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("violation_pready2", {31'b0, pready[0]}, 32'h0);
        @(posedge PCLK); #1;
        psel[0] = 0; penable[0] = 0;

`ifdef APB_SLAVE_PSTRB_EN
        xfer(0, 1, 32'h00, 32'hFFFFFFFF, 4'hF, rd, er, nacc);
        xfer(0, 1, 32'h00, 32'h11223344, 4'b0101, rd, er, nacc);
        xfer(0, 0, 32'h00, 32'h0, 4'h0, rd, er, nacc);
        chk("pstrb_partial", rd, 32'hFF22FF44);
        xfer(0, 1, 32'h00, 32'h00000000, 4'b0000, rd, er, nacc);
        chk("pstrb_zero_err", {31'b0, er}, 32'h0);
        xfer(0, 0, 32'h00, 32'h0, 4'hF, rd, er, nacc);
        chk("pstrb_zero_unchanged", rd, 32'hFF22FF44);
`endif

        // Asynchronous reset mid-ACCESS while a read is presenting data.
        psel[0] = 1; penable[0] = 0; pwrite[0] = 0; paddr[0] = 32'h04;
        @(posedge PCLK); #1;
        penable[0] = 1;
        @(negedge PCLK);
        chk("prereset_pready", {31'b0, pready[0]}, 32'h1);
        chk("prereset_prdata", prdata[0], 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_pready",  {31'b0, pready[0]},  32'h0);
        chk("async_reset_prdata",  prdata[0],           32'h0);
        chk("async_reset_pslverr", {31'b0, pslverr[0]}, 32'h0);
        psel[0] = 0; penable[0] = 0;
        @(posedge PCLK); #1;
        rst_n = 1'b1;
        @(posedge PCLK); #1;
        xfer(0, 0, 32'h04, 32'h0, 4'hF, rd, er, nacc);
        chk("post_reset_read", rd, 32'h0);
        xfer(1, 0, 32'h04, 32'h0, 4'hF, rd, er, nacc);
        chk("post_reset_read_w2", rd, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
